// File: rtl/pwm_pkg.sv
// Shared definitions for the multi-channel PWM: mode encodings, counter
// width and the saturating minimum used to clamp channel widths.
package pwm_pkg;

    localparam logic MODO_ALINHADO = 1'b0;
    localparam logic MODO_DEFASADO = 1'b1;

    localparam int CONT_BITS = 32;

    // Smaller of two unsigned values; clamps a requested width to the period.
    function automatic logic [CONT_BITS-1:0] sat_min(
        input logic [CONT_BITS-1:0] valor,
        input logic [CONT_BITS-1:0] limite
    );
        return (valor < limite) ? valor : limite;
    endfunction

endpackage

// File: rtl/pwm_canal.sv
// One PWM channel: phase offset from the shared counter, width saturation,
// slew-limited shadow register and the registered output compare.
module pwm_canal
    import pwm_pkg::*;
#(
    parameter int CONF_PERIODO = 1250,
    parameter int LARGURA_BITS = 11,
    parameter int PASSO_MAX    = 0,
    parameter int DESLOC       = 0
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    modo_ativo,
    input  logic [CONT_BITS-1:0]    contagem,
    input  logic [LARGURA_BITS-1:0] largura,
    output logic                    pwm
);

    localparam logic [CONT_BITS-1:0] PERIODO  = CONT_BITS'(CONF_PERIODO);
    localparam logic [CONT_BITS-1:0] ULTIMO   = PERIODO - 1'b1;
    localparam logic [CONT_BITS-1:0] DESLOC_V = CONT_BITS'(DESLOC);
    localparam logic [CONT_BITS-1:0] PASSO    = CONT_BITS'(PASSO_MAX);

    logic [CONT_BITS-1:0] desloc;
    logic [CONT_BITS-1:0] fase;
    logic [CONT_BITS-1:0] alvo;
    logic [CONT_BITS-1:0] atual;
    logic [CONT_BITS-1:0] proximo;

    // Channel phase, saturated target and next applied width (slew-limited).
    always_comb begin
        desloc = (modo_ativo == MODO_DEFASADO) ? DESLOC_V : '0;
        // Offset is always below the period, so one conditional add replaces a modulo.
        if (contagem >= desloc)
            fase = contagem - desloc;
        else
            fase = contagem + PERIODO - desloc;

        alvo    = sat_min(CONT_BITS'(largura), PERIODO);
        proximo = atual;
        if (PASSO_MAX == 0)
            proximo = alvo;
        else if (alvo > atual)
            proximo = ((alvo - atual) <= PASSO) ? alvo : atual + PASSO;
        else
            proximo = ((atual - alvo) <= PASSO) ? alvo : atual - PASSO;
    end

    // Shadow width loads only at this channel's own phase boundary; output compare is registered.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            atual <= '0;
            pwm   <= 1'b0;
        end else begin
            if (enable && (fase == ULTIMO))
                atual <= proximo;
            pwm <= enable && (fase < atual);
        end
    end

endmodule

// File: rtl/pwm_multicanal.sv
// Multi-channel PWM top: shared period counter, mode sampling at the period
// boundary, end-of-period marker and one pwm_canal per channel.
module pwm_multicanal
    import pwm_pkg::*;
#(
    parameter int CONF_PERIODO = 1250,
    parameter int N_CANAIS     = 4,
    parameter int LARGURA_BITS = 11,
    parameter int PASSO_MAX    = 0
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             enable,
    input  logic                             modo,
    input  logic [N_CANAIS*LARGURA_BITS-1:0] largura,
    output logic [N_CANAIS-1:0]              pwm,
    output logic                             fim_periodo
);

    localparam logic [CONT_BITS-1:0] ULTIMO = CONT_BITS'(CONF_PERIODO) - 1'b1;

    logic [CONT_BITS-1:0] contagem;
    logic                 modo_ativo;
    logic                 ultimo_ciclo;

    assign ultimo_ciclo = (contagem == ULTIMO);

    // Period counter, held at zero while stopped; mode is only taken at the wrap.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            contagem    <= '0;
            modo_ativo  <= MODO_ALINHADO;
            fim_periodo <= 1'b0;
        end else begin
            fim_periodo <= enable && ultimo_ciclo;
            if (!enable) begin
                contagem <= '0;
            end else if (ultimo_ciclo) begin
                contagem   <= '0;
                modo_ativo <= modo;
            end else begin
                contagem <= contagem + 1'b1;
            end
        end
    end

    for (genvar i = 0; i < N_CANAIS; i++) begin : g_canal
        pwm_canal #(
            .CONF_PERIODO (CONF_PERIODO),
            .LARGURA_BITS (LARGURA_BITS),
            .PASSO_MAX    (PASSO_MAX),
            .DESLOC       ((i * CONF_PERIODO) / N_CANAIS)
        ) u_canal (
            .clock      (clock),
            .reset      (reset),
            .enable     (enable),
            .modo_ativo (modo_ativo),
            .contagem   (contagem),
            .largura    (largura[i*LARGURA_BITS +: LARGURA_BITS]),
            .pwm        (pwm[i])
        );
    end

endmodule

// File: tb/tb_pwm_multicanal.sv
// Directed bench for pwm_multicanal: one unlimited-slew instance and one
// instance with PASSO_MAX=4 share clock, reset, enable and mode.
module tb_pwm_multicanal;

    localparam int P  = 20;
    localparam int N  = 4;
    localparam int LB = 6;

    logic            clock = 1'b0;
    logic            reset;
    logic            enable;
    logic            modo;
    logic [N*LB-1:0] largura;
    logic [N*LB-1:0] largura_s;
    logic [N-1:0]    pwm;
    logic [N-1:0]    pwm_s;
    logic            fim;
    logic            fim_s;

    int checks = 0;
    int errors = 0;
    int cnt    = 0;
    int prev   = 0;
    int alto   [N];
    int alto_s [N];
    int n_fim;
    logic fim_ultimo;

    always #5 clock = ~clock;

    pwm_multicanal #(
        .CONF_PERIODO (P),
        .N_CANAIS     (N),
        .LARGURA_BITS (LB),
        .PASSO_MAX    (0)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .modo        (modo),
        .largura     (largura),
        .pwm         (pwm),
        .fim_periodo (fim)
    );

    pwm_multicanal #(
        .CONF_PERIODO (P),
        .N_CANAIS     (N),
        .LARGURA_BITS (LB),
        .PASSO_MAX    (4)
    ) dut_s (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .modo        (modo),
        .largura     (largura_s),
        .pwm         (pwm_s),
        .fim_periodo (fim_s)
    );

    // One clock; prev is the counter value the DUT held at this edge.
    task automatic step();
        prev = cnt;
        @(posedge clock);
        if (reset || !enable) cnt = 0;
        else cnt = (cnt == P-1) ? 0 : cnt + 1;
        #1;
    endtask

    task automatic set_larg(input int ch, input int w);
        largura[ch*LB +: LB] = LB'(w);
    endtask

    task automatic set_larg_s(input int ch, input int w);
        largura_s[ch*LB +: LB] = LB'(w);
    endtask

    // Count high cycles per channel over one 20-clock window.
    task automatic medir();
        for (int c = 0; c < N; c++) begin
            alto[c] = 0;
            alto_s[c] = 0;
        end
        n_fim = 0;
        fim_ultimo = 1'b0;
        for (int k = 0; k < P; k++) begin
            step();
            for (int c = 0; c < N; c++) begin
                alto[c]   += int'(pwm[c]);
                alto_s[c] += int'(pwm_s[c]);
            end
            n_fim += int'(fim);
            fim_ultimo = fim;
        end
    endtask

    task automatic ate_inicio();
        int g = 0;
        while (cnt != 0 && g < 2*P) begin
            step();
            g++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; modo = 1'b0;
        largura = '0; largura_s = '0;
        repeat (3) step();
        checks++; if (pwm !== 4'b0) begin errors++; $display("FAIL reset_pwm got %b want 0000", pwm); end
        checks++; if (fim !== 1'b0) begin errors++; $display("FAIL reset_fim got %b want 0", fim); end
        checks++; if (pwm_s !== 4'b0) begin errors++; $display("FAIL reset_pwm_s got %b want 0000", pwm_s); end
    endtask

    task automatic test_alinhado();
        set_larg(0, 5);
        enable = 1'b1;
        reset  = 1'b0;
        cnt    = 0;
        for (int k = 0; k < P; k++) begin
            step();
            checks++; if (pwm !== 4'b0) begin errors++; $display("FAIL first_period prev=%0d got %b want 0000", prev, pwm); end
            checks++; if (fim !== (prev == P-1)) begin errors++; $display("FAIL fim_first prev=%0d got %b want %b", prev, fim, prev == P-1); end
        end
        for (int k = 0; k < 2*P; k++) begin
            step();
            checks++; if (pwm[0] !== (prev < 5)) begin errors++; $display("FAIL edge_ch0 prev=%0d got %b want %b", prev, pwm[0], prev < 5); end
            checks++; if (pwm[3:1] !== 3'b0) begin errors++; $display("FAIL edge_others prev=%0d got %b want 000", prev, pwm[3:1]); end
            checks++; if (fim !== (prev == P-1)) begin errors++; $display("FAIL fim prev=%0d got %b want %b", prev, fim, prev == P-1); end
        end
    endtask

    task automatic test_slew();
        int sobe  [6] = '{4, 8, 12, 16, 18, 18};
        int desce [6] = '{18, 14, 10, 6, 2, 2};
        ate_inicio();
        set_larg_s(1, 18);
        medir();
        checks++; if (alto_s[1] !== 0) begin errors++; $display("FAIL slew_start got %0d want 0", alto_s[1]); end
        for (int j = 0; j < 6; j++) begin
            medir();
            checks++; if (alto_s[1] !== sobe[j]) begin errors++; $display("FAIL slew_up[%0d] got %0d want %0d", j, alto_s[1], sobe[j]); end
        end
        set_larg_s(1, 2);
        for (int j = 0; j < 6; j++) begin
            medir();
            checks++; if (alto_s[1] !== desce[j]) begin errors++; $display("FAIL slew_down[%0d] got %0d want %0d", j, alto_s[1], desce[j]); end
        end
    endtask

    task automatic test_saturacao();
        ate_inicio();
        set_larg(2, 63);
        medir();
        checks++; if (alto[2] !== 0) begin errors++; $display("FAIL sat_before got %0d want 0", alto[2]); end
        for (int k = 0; k < 2*P; k++) begin
            step();
            checks++; if (pwm[2] !== 1'b1) begin errors++; $display("FAIL sat_high prev=%0d got %b want 1", prev, pwm[2]); end
            checks++; if (pwm[0] !== (prev < 5)) begin errors++; $display("FAIL sat_ch0 prev=%0d got %b want %b", prev, pwm[0], prev < 5); end
        end
        set_larg(2, 0);
        medir();
        checks++; if (alto[2] !== P) begin errors++; $display("FAIL sat_tail got %0d want %0d", alto[2], P); end
        medir();
        checks++; if (alto[2] !== 0) begin errors++; $display("FAIL sat_zero got %0d want 0", alto[2]); end
    endtask

    task automatic test_defasado();
        logic [N-1:0] esperado;
        ate_inicio();
        modo = 1'b1;
        for (int c = 0; c < N; c++) set_larg(c, 5);
        medir();
        checks++; if (alto[0] !== 5 || alto[1] !== 0 || alto[2] !== 0 || alto[3] !== 0) begin
            errors++; $display("FAIL stag_pre got %0d %0d %0d %0d want 5 0 0 0", alto[0], alto[1], alto[2], alto[3]);
        end
        for (int k = 0; k < 2*P; k++) begin
            step();
            esperado = 4'b0001 << (prev / 5);
            checks++; if (pwm !== esperado) begin errors++; $display("FAIL stagger prev=%0d got %b want %b", prev, pwm, esperado); end
        end
        modo = 1'b0;
        set_larg(0, 5);
        for (int c = 1; c < N; c++) set_larg(c, 0);
        medir();
        medir();
        checks++; if (alto[0] !== 5 || alto[1] !== 0 || alto[2] !== 0 || alto[3] !== 0) begin
            errors++; $display("FAIL stag_back got %0d %0d %0d %0d want 5 0 0 0", alto[0], alto[1], alto[2], alto[3]);
        end
    endtask

    task automatic test_limite();
        int h = 0;
        ate_inicio();
        for (int k = 0; k < 3; k++) begin step(); h += int'(pwm[0]); end
        set_larg(0, 10);
        for (int k = 3; k < P; k++) begin step(); h += int'(pwm[0]); end
        checks++; if (h !== 5) begin errors++; $display("FAIL midchange_cur got %0d want 5", h); end
        medir();
        checks++; if (alto[0] !== 10) begin errors++; $display("FAIL midchange_next got %0d want 10", alto[0]); end
        step(); step();
        checks++; if (pwm[0] !== 1'b1) begin errors++; $display("FAIL prereset_ch0 got %b want 1", pwm[0]); end
        reset = 1'b1;
        #1;
        checks++; if (pwm !== 4'b0) begin errors++; $display("FAIL async_reset_pwm got %b want 0000", pwm); end
        checks++; if (fim !== 1'b0) begin errors++; $display("FAIL async_reset_fim got %b want 0", fim); end
        step();
        reset = 1'b0;
        medir();
        checks++; if (alto[0] !== 0) begin errors++; $display("FAIL after_reset got %0d want 0", alto[0]); end
        checks++; if (n_fim !== 1 || fim_ultimo !== 1'b1) begin errors++; $display("FAIL after_reset_fim got %0d/%b want 1/1", n_fim, fim_ultimo); end
        medir();
        checks++; if (alto[0] !== 10) begin errors++; $display("FAIL after_reset_next got %0d want 10", alto[0]); end
    endtask

    task automatic test_parada();
        ate_inicio();
        repeat (3) step();
        checks++; if (pwm[0] !== 1'b1) begin errors++; $display("FAIL prestop_ch0 got %b want 1", pwm[0]); end
        enable = 1'b0;
        set_larg(0, 3);
        for (int k = 0; k < P + 5; k++) begin
            step();
            checks++; if (pwm !== 4'b0) begin errors++; $display("FAIL stop_pwm k=%0d got %b want 0000", k, pwm); end
            checks++; if (fim !== 1'b0) begin errors++; $display("FAIL stop_fim k=%0d got %b want 0", k, fim); end
        end
        enable = 1'b1;
        medir();
        checks++; if (alto[0] !== 10) begin errors++; $display("FAIL restart_held got %0d want 10", alto[0]); end
        checks++; if (n_fim !== 1 || fim_ultimo !== 1'b1) begin errors++; $display("FAIL restart_fim got %0d/%b want 1/1", n_fim, fim_ultimo); end
        medir();
        checks++; if (alto[0] !== 3) begin errors++; $display("FAIL restart_new got %0d want 3", alto[0]); end
    endtask

    initial begin
        test_reset();
        test_alinhado();
        test_slew();
        test_saturacao();
        test_defasado();
        test_limite();
        test_parada();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pwm_multicanal.md
# pwm_multicanal

Multi-channel PWM generator and parametrised successor of the single-channel 3-bit-table PWM. It drives `N_CANAIS` outputs from one shared period counter. Each channel takes a direct width value instead of a fixed table, with shadow-register update, saturation and an optional per-period slew limit for smooth servo/actuator motion. An optional phase-staggered mode spreads the channel pulses evenly over the period. It sits between the control FSM, which writes the widths, and the output pins.

## Interface
- `CONF_PERIODO`, default 1250: period in clocks (1250 gives 40 kHz at 50 MHz); must be ≥ 2.
- `N_CANAIS`, default 4: number of channels; must be ≥ 1.
- `LARGURA_BITS`, default 11: bits per channel width field.
- `PASSO_MAX`, default 0: maximum change of the applied width per period; 0 means no limit.
- `clock` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `enable` in 1: run/stop.
- `modo` in 1: 0 means edge-aligned; 1 means phase-staggered.
- `largura` in `N_CANAIS*LARGURA_BITS`: packed target widths; channel i occupies bits `[i*LARGURA_BITS +: LARGURA_BITS]`.
- `pwm` out `N_CANAIS`: PWM outputs, registered.
- `fim_periodo` out 1: one-clock pulse marking the end of each period, registered.

## Operation
- **Shared counter.** `contagem` counts 0..`CONF_PERIODO`-1 and wraps to 0. It is 32 bits wide.
- **Phase offset.** Each channel has a constant offset `desloc_i = (i*CONF_PERIODO)/N_CANAIS`, using integer division.
  - `modo_ativo`=1: `desloc_i` as defined.
  - `modo_ativo`=0: `desloc_i` = 0 for all channels.
- **Channel phase.** `fase_i = (contagem - desloc_i) mod CONF_PERIODO`, computed without a divider by a compare-and-add of `CONF_PERIODO`.
- **Output compare.** `pwm[i]` is registered from `fase_i < atual_i`, where `atual_i` is the applied width in the shadow register.
- **Target saturation.** Target `alvo_i = min(largura_i, CONF_PERIODO)`.
  - Width 0 gives constant low.
  - Width ≥ `CONF_PERIODO` gives constant high with no glitch at the wrap.
- **Shadow update.** The update happens on the cycle where `fase_i == CONF_PERIODO-1`, so each channel updates at its own boundary and a pulse is never split.
  - `PASSO_MAX`=0: `atual_i <= alvo_i`.
  - Otherwise: if `|alvo_i - atual_i| ≤ PASSO_MAX`, then `atual_i <= alvo_i`. Else `atual_i` moves toward `alvo_i` by exactly `PASSO_MAX`.
- **Mid-period width changes.** Changes to `largura` between boundaries are ignored; only the value present on the update cycle counts.
- **Mode sampling.** `modo` is sampled into `modo_ativo` only when `contagem == CONF_PERIODO-1`. A mode change may truncate or extend the pulse that follows it; this is accepted.
- **Stop (`enable`=0).**
  - `contagem` is forced to 0.
  - `pwm` is 0 and `fim_periodo` is 0.
  - `atual_i` and `modo_ativo` are held.
  - When `enable` returns to 1, counting restarts from 0.
- **Period marker.** `fim_periodo` is asserted for the one clock that follows `contagem == CONF_PERIODO-1`.

## Timing
- **Reset values.** `contagem`=0, all `atual_i`=0, `modo_ativo`=0, `pwm`=0, `fim_periodo`=0. Reset is asynchronous, so outputs drop to 0 immediately, including mid-pulse.
- **Output latency.** `pwm` is one clock behind `contagem`: the output in cycle t reflects `fase` in cycle t-1.
- **Width latency.** A new width takes effect in the channel period after the next `fase_i` boundary. A full step therefore becomes visible 1 to `CONF_PERIODO`+1 clocks later.
- **Slew duration.** A slewed transition of size D needs ceil(D/`PASSO_MAX`) periods.
- **Marker alignment.** `fim_periodo` coincides with the `pwm` sample derived from `contagem = CONF_PERIODO-1`.
- **First period.** The first period after reset is all-low, because `atual` is 0.

## Structure
- **Package `pwm_pkg`.** Holds the mode encodings `MODO_ALINHADO`=0 and `MODO_DEFASADO`=1, the counter width constant (32), and a saturating-minimum function.
- **Sub-module `pwm_canal`.** Per-channel logic: offset phase, saturation, slew shadow register and output flop. Parameters are `CONF_PERIODO`, `LARGURA_BITS`, `PASSO_MAX`, `DESLOC`.
- **Top level.** Holds the shared counter, `modo_ativo` and `fim_periodo`, and instantiates `N_CANAIS` copies of `pwm_canal` with a generate loop.

## Test plan
Bench parameters: `CONF_PERIODO`=20, `N_CANAIS`=4, `LARGURA_BITS`=6.

1. **Edge-aligned, no slew.** `PASSO_MAX`=0, `modo`=0, ch0 width=5. Release reset with `enable`=1 -> first period all low, then `pwm[0]` high for 5 of every 20 clocks starting one clock after `contagem`=0; `fim_periodo` pulses every 20 clocks.
2. **Slew limit.** `PASSO_MAX`=4, ch1 width 0->18 -> applied widths on successive periods are 4, 8, 12, 16, 18, then stable. Width 18->2 gives 14, 10, 6, 2.
3. **Saturation.** ch2 width=63 -> `pwm[2]` constant high across wraps. ch2 width=0 -> constant low.
4. **Phase-staggered mode.** `modo`=1, all widths=5 -> after the next boundary, ch0..ch3 are high for counts 0-4, 5-9, 10-14 and 15-19 respectively (each +1 clock latency), with no overlap.
5. **Boundary behaviour.** Change ch0 width 5->10 at `contagem`=3 -> the current pulse stays 5 wide and the next period is 10 wide. Pulse `reset` at `contagem`=2 -> all outputs low in the same cycle and the first period after release is all-low.
6. **Stop/restart.** Deassert `enable` mid-pulse -> `pwm` goes low the next clock and `fim_periodo` stays 0. Reassert -> counting restarts from 0 using the held widths.
